// File: rtl/fetch_controller_pkg.sv
// rtl/fetch_controller_pkg.sv - shared types and constants for the fetch front end
//
// Purpose: state encoding for the fetch state machine and the instruction
// word width shared by fetch_controller and instr_skid.
// Ports: none (package).

package fetch_controller_pkg;

    localparam int INSTR_WIDTH = 16;

    typedef enum logic [1:0] {
        FC_LOAD = 2'd0,
        FC_FILL = 2'd1,
        FC_RUN  = 2'd2,
        FC_HALT = 2'd3
    } fc_state_e;

    // Branch and halt requests are only honoured while the front end is
    // actively sequencing the PC; HALT waits exclusively for resume.
    function automatic logic fc_accepts_redirect(input fc_state_e state);
        return state != FC_HALT;
    endfunction

endpackage

// File: rtl/fetch_controller_instr_skid.sv
// rtl/fetch_controller_instr_skid.sv - one-entry skid register for stalled instructions
//
// Purpose: holds the instruction word (and its address) that was on the ROM
// output when the decoder stalled, so the ROM output can move on to the next
// word without losing the stalled one.
// Ports:
//   i_clk      system clock
//   i_reset    synchronous active-high reset, empties the register
//   i_capture  load i_data/i_addr and mark full
//   i_clear    mark empty after the held word has been accepted
//   i_flush    discard contents (redirect or halt); wins over clear/capture
//   i_data     instruction word to capture
//   i_addr     address of the instruction word to capture
//   o_full     register holds a word
//   o_data     held instruction word
//   o_addr     address of held instruction word

module instr_skid
    import fetch_controller_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_capture,
    input  logic                   i_clear,
    input  logic                   i_flush,
    input  logic [INSTR_WIDTH-1:0] i_data,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    output logic                   o_full,
    output logic [INSTR_WIDTH-1:0] o_data,
    output logic [ADDR_WIDTH-1:0]  o_addr
);

    logic                   full_q;
    logic [INSTR_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH-1:0]  addr_q;

    // Only the full flag needs reset; the payload is ignored while empty.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            full_q <= 1'b0;
        end else if (i_clear) begin
            full_q <= 1'b0;
        end else if (i_capture) begin
            full_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_capture && !i_flush && !i_clear) begin
            data_q <= i_data;
            addr_q <= i_addr;
        end
    end

    assign o_full = full_q;
    assign o_data = data_q;
    assign o_addr = addr_q;

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC/ROM sequencer with valid/ready decoder handshake
//
// Purpose: drives the program counter's load/increment strobes, hides the
// one-cycle ROM read latency and presents instructions to the decoder with a
// valid/ready handshake. Handles reset-vector fetch, taken-branch redirects,
// decoder back-pressure through a one-entry skid register, and halt/resume.
// Ports:
//   i_clk             system clock
//   i_reset           synchronous active-high reset
//   i_pc_instruction  ROM word, one cycle behind the PC address
//   o_pc_inc          PC increment strobe
//   o_pc_load         PC load strobe (priority over increment in the PC)
//   o_pc_addr         PC load target
//   o_instr_valid     o_instruction / o_instr_addr valid
//   i_instr_ready     decoder accepts; transfer = valid && ready
//   o_instruction     presented instruction, zero when not valid
//   o_instr_addr      address of presented instruction
//   i_branch          taken-branch pulse
//   i_branch_addr     branch target
//   i_halt            stop fetching
//   i_resume          leave HALT
//   o_halted          high in HALT

module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [INSTR_WIDTH-1:0] i_pc_instruction,
    output logic                   o_pc_inc,
    output logic                   o_pc_load,
    output logic [ADDR_WIDTH-1:0]  o_pc_addr,
    output logic                   o_instr_valid,
    input  logic                   i_instr_ready,
    output logic [INSTR_WIDTH-1:0] o_instruction,
    output logic [ADDR_WIDTH-1:0]  o_instr_addr,
    input  logic                   i_branch,
    input  logic [ADDR_WIDTH-1:0]  i_branch_addr,
    input  logic                   i_halt,
    input  logic                   i_resume,
    output logic                   o_halted
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    fc_state_e               state_q, state_d;
    logic [ADDR_WIDTH-1:0]   target_q, target_d;
    logic [ADDR_WIDTH-1:0]   instr_addr_q, instr_addr_d;

    logic                    skid_full;
    logic [INSTR_WIDTH-1:0]  skid_data;
    logic [ADDR_WIDTH-1:0]   skid_addr;
    logic                    skid_capture;
    logic                    skid_clear;
    logic                    skid_flush;

    logic                    valid;
    logic                    transfer;
    logic                    pc_inc;
    logic                    pc_load;
    logic                    halted;
    logic [ADDR_WIDTH-1:0]   addr_after_transfer;

    instr_skid #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_skid (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_capture (skid_capture),
        .i_clear   (skid_clear),
        .i_flush   (skid_flush),
        .i_data    (i_pc_instruction),
        .i_addr    (instr_addr_q),
        .o_full    (skid_full),
        .o_data    (skid_data),
        .o_addr    (skid_addr)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= FC_LOAD;
            target_q     <= RESET_VECTOR;
            instr_addr_q <= RESET_VECTOR;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            instr_addr_q <= instr_addr_d;
        end
    end

    // valid depends on state only, so transfer is a pure function of state
    // and i_instr_ready.
    assign valid               = (state_q == FC_RUN);
    assign transfer            = valid && i_instr_ready;
    assign addr_after_transfer = transfer ? instr_addr_q + ADDR_ONE : instr_addr_q;

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        instr_addr_d = instr_addr_q;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        halted       = 1'b0;
        skid_capture = 1'b0;
        skid_clear   = 1'b0;
        skid_flush   = 1'b0;

        unique case (state_q)
            FC_LOAD: begin
                pc_load = 1'b1;
                state_d = FC_FILL;
            end
            FC_FILL: begin
                // The ROM output this cycle is stale; advancing the PC now
                // puts target+1 on the address so the word for target
                // arrives next cycle and target+1 the cycle after.
                pc_inc       = 1'b1;
                instr_addr_d = target_q;
                state_d      = FC_RUN;
            end
            FC_RUN: begin
                // The PC only advances on acceptance. On a stall the ROM
                // output still moves one word ahead (it was already one
                // address behind the PC), so the stalled word is parked in
                // the skid while the ROM keeps showing its successor.
                pc_inc       = transfer;
                skid_capture = !skid_full && !transfer;
                skid_clear   = skid_full && transfer;
                instr_addr_d = addr_after_transfer;
            end
            FC_HALT: begin
                halted = 1'b1;
                if (i_resume) begin
                    state_d = FC_LOAD;
                end
            end
            default: begin
                state_d = FC_LOAD;
            end
        endcase

        // Redirects override the normal sequencing. A transfer in the same
        // cycle still completes on the decoder side; the PC is reloaded, so
        // it must not be incremented.
        if (fc_accepts_redirect(state_q)) begin
            if (i_halt) begin
                pc_inc       = 1'b0;
                skid_capture = 1'b0;
                skid_clear   = 1'b0;
                skid_flush   = 1'b1;
                state_d      = FC_HALT;
                if (i_branch) begin
                    target_d = i_branch_addr;
                end else if (state_q == FC_RUN) begin
                    target_d = addr_after_transfer;
                end else begin
                    target_d = target_q;
                end
            end else if (i_branch) begin
                pc_inc       = 1'b0;
                skid_capture = 1'b0;
                skid_clear   = 1'b0;
                skid_flush   = 1'b1;
                target_d     = i_branch_addr;
                state_d      = FC_LOAD;
            end
        end
    end

    assign o_pc_inc      = pc_inc;
    assign o_pc_load     = pc_load;
    assign o_pc_addr     = target_q;
    assign o_halted      = halted;
    assign o_instr_valid = valid;
    assign o_instruction = !valid    ? '0 :
                           skid_full ? skid_data : i_pc_instruction;
    // While the skid is full its address equals instr_addr_q; taking it from
    // the skid keeps word and address paired by construction.
    assign o_instr_addr  = skid_full ? skid_addr : instr_addr_q;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed self-checking bench for fetch_controller

module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rom_q;
    logic        pc_inc;
    logic        pc_load;
    logic [7:0]  pc_addr;
    logic        valid;
    logic        rdy;
    logic [15:0] instr;
    logic [7:0]  iaddr;
    logic        br;
    logic [7:0]  bra;
    logic        hlt;
    logic        res;
    logic        halted;
    logic [7:0]  pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Program counter plus synchronous ROM, word[a] = A000 + a.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= 8'h00;
        end else if (pc_load) begin
            pc <= pc_addr;
        end else if (pc_inc) begin
            pc <= pc + 8'h01;
        end
        rom_q <= 16'hA000 + {8'h00, pc};
    end

    fetch_controller #(
        .ADDR_WIDTH   (8),
        .RESET_VECTOR (8'h00)
    ) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_pc_instruction (rom_q),
        .o_pc_inc         (pc_inc),
        .o_pc_load        (pc_load),
        .o_pc_addr        (pc_addr),
        .o_instr_valid    (valid),
        .i_instr_ready    (rdy),
        .o_instruction    (instr),
        .o_instr_addr     (iaddr),
        .i_branch         (br),
        .i_branch_addr    (bra),
        .i_halt           (hlt),
        .i_resume         (res),
        .o_halted         (halted)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_word(input string tag, input int a);
        chk({tag, "_valid"}, 32'(valid), 1);
        chk({tag, "_instr"}, 32'(instr), 32'(16'hA000 + a));
        chk({tag, "_addr"}, 32'(iaddr), a);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; br = 1'b0; bra = 8'h00; hlt = 1'b0; res = 1'b0;
        repeat (3) cyc();

        // Reset: LOAD, FILL, then first word at reset+3.
        rst = 1'b0; settle();
        chk("rst_load",    32'(pc_load), 1);
        chk("rst_pc_addr", 32'(pc_addr), 0);
        chk("rst_valid",   32'(valid), 0);
        chk("rst_instr",   32'(instr), 0);
        chk("rst_halted",  32'(halted), 0);
        cyc(); settle();
        chk("fill_inc",   32'(pc_inc), 1);
        chk("fill_load",  32'(pc_load), 0);
        chk("fill_valid", 32'(valid), 0);
        cyc(); settle();
        chk_word("first", 0);
        chk("first_inc", 32'(pc_inc), 1);
        for (int a = 1; a <= 5; a++) begin
            cyc(); settle();
            chk_word("stream", a);
        end

        // Stall three cycles on A005.
        rdy = 1'b0; settle();
        chk("stall_inc0", 32'(pc_inc), 0);
        for (int s = 1; s <= 2; s++) begin
            cyc(); settle();
            chk_word("stall_hold", 5);
            chk("stall_inc", 32'(pc_inc), 0);
        end
        cyc(); rdy = 1'b1; settle();
        chk_word("stall_release", 5);
        chk("release_inc", 32'(pc_inc), 1);
        for (int a = 6; a <= 16; a++) begin
            cyc(); settle();
            chk_word("after_stall", a);
        end

        // Branch to 0x40 during transfer of A010.
        br = 1'b1; bra = 8'h40; settle();
        chk("br_inc_forced", 32'(pc_inc), 0);
        chk("br_valid", 32'(valid), 1);
        cyc(); br = 1'b0; settle();
        chk("br_b1_valid", 32'(valid), 0);
        chk("br_b1_load",  32'(pc_load), 1);
        chk("br_b1_addr",  32'(pc_addr), 32'h40);
        cyc(); settle();
        chk("br_b2_valid", 32'(valid), 0);
        cyc(); settle();
        chk_word("br_target", 32'h40);
        cyc(); settle();
        chk_word("br_next", 32'h41);

        // Branch to 0x20 while stalled (no transfer).
        rdy = 1'b0; br = 1'b1; bra = 8'h20; settle();
        chk("br_stall_inc", 32'(pc_inc), 0);
        cyc(); br = 1'b0; rdy = 1'b1; settle();
        chk("br2_load", 32'(pc_load), 1);
        chk("br2_addr", 32'(pc_addr), 32'h20);
        cyc(); cyc(); settle();
        chk_word("br2_target", 32'h20);

        // Halt while A020 is accepted; branch in HALT is ignored.
        hlt = 1'b1; settle();
        cyc(); hlt = 1'b0; settle();
        chk("halt_halted", 32'(halted), 1);
        chk("halt_valid",  32'(valid), 0);
        chk("halt_load",   32'(pc_load), 0);
        chk("halt_inc",    32'(pc_inc), 0);
        br = 1'b1; bra = 8'h99;
        for (int h = 2; h <= 4; h++) begin
            cyc(); settle();
            chk("halt_stay", 32'(halted), 1);
            chk("halt_stay_valid", 32'(valid), 0);
        end
        cyc(); br = 1'b0; res = 1'b1; settle();
        chk("resume_cycle_halted", 32'(halted), 1);
        cyc(); res = 1'b0; settle();
        chk("resume_halted", 32'(halted), 0);
        chk("resume_load",   32'(pc_load), 1);
        chk("resume_addr",   32'(pc_addr), 32'h21);
        cyc(); settle();
        chk("resume_fill_valid", 32'(valid), 0);
        cyc(); settle();
        chk_word("resume_first", 32'h21);

        // Simultaneous halt and branch to 0x80, then resume.
        hlt = 1'b1; br = 1'b1; bra = 8'h80; settle();
        cyc(); hlt = 1'b0; br = 1'b0; res = 1'b1; settle();
        chk("hb_halted", 32'(halted), 1);
        cyc(); res = 1'b0; settle();
        chk("hb_load_addr", 32'(pc_addr), 32'h80);
        cyc(); cyc(); settle();
        chk_word("hb_first", 32'h80);

        // Wrap from 0xFF to 0x00.
        br = 1'b1; bra = 8'hFD; settle();
        cyc(); br = 1'b0; cyc(); cyc(); settle();
        chk_word("wrap_fd", 32'hFD);
        cyc(); settle(); chk_word("wrap_fe", 32'hFE);
        cyc(); settle(); chk_word("wrap_ff", 32'hFF);
        cyc(); settle(); chk_word("wrap_00", 0);
        cyc(); settle(); chk_word("wrap_01", 1);

        // Reset mid-stall with the skid full of A001.
        rdy = 1'b0; settle();
        cyc(); settle();
        chk_word("pre_reset_skid", 1);
        rst = 1'b1; settle();
        cyc(); rst = 1'b0; rdy = 1'b1; settle();
        chk("mrst_load",   32'(pc_load), 1);
        chk("mrst_addr",   32'(pc_addr), 0);
        chk("mrst_valid",  32'(valid), 0);
        chk("mrst_halted", 32'(halted), 0);
        cyc(); settle();
        chk("mrst_fill_valid", 32'(valid), 0);
        cyc(); settle();
        chk_word("mrst_first", 0);
        cyc(); settle();
        chk_word("mrst_second", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
